// File: rtl/mlp_seq_ctrl_if.sv
// Handshake and weight-memory bundle for the shared-MAC MLP sequencer.
// The controller takes the slave side; the environment (source, sink, weight RAM) takes the master side.
interface mlp_seq_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int IN_DIM  = 3,
  parameter int OUT_DIM = 1,
  parameter int ADDR_W  = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [IN_DIM*DATA_W-1:0]  in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_DIM*DATA_W-1:0] out_data;
  logic                      w_rd_en;
  logic [ADDR_W-1:0]         w_addr;
  logic [DATA_W-1:0]         w_data;
  logic                      busy;

  modport slave (
    input  in_valid, in_data, out_ready, w_data,
    output in_ready, out_valid, out_data, w_rd_en, w_addr, busy
  );

  modport master (
    output in_valid, in_data, out_ready, w_data,
    input  in_ready, out_valid, out_data, w_rd_en, w_addr, busy
  );
endinterface

// File: rtl/mlp_seq_ctrl.sv
// Runs a 2-layer MLP (ReLU after each layer) one neuron at a time on a single MAC,
// streaming weights from a 1-cycle-latency synchronous memory.
module mlp_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int IN_DIM  = 3,
  parameter int L1_DIM  = 3,
  parameter int OUT_DIM = 1,
  parameter int ADDR_W  = 8
) (
  input  logic          clk,
  input  logic          reset,
  mlp_seq_ctrl_if.slave bus
);
  localparam int K_MAX   = (IN_DIM > L1_DIM) ? IN_DIM : L1_DIM;
  localparam int N_MAX   = (L1_DIM > OUT_DIM) ? L1_DIM : OUT_DIM;
  localparam int K_W     = $clog2(K_MAX + 1);
  localparam int N_W     = $clog2(N_MAX + 1);
  localparam int L2_BASE = L1_DIM * IN_DIM;

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

  state_t            state_reg, state_next;
  logic [K_W-1:0]    k_reg, k_next;
  logic [N_W-1:0]    n_reg, n_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic [DATA_W-1:0] x_reg      [IN_DIM];
  logic [DATA_W-1:0] hidden_reg [L1_DIM];
  logic [DATA_W-1:0] out_reg    [OUT_DIM];
  logic [DATA_W-1:0] in_elem    [IN_DIM];

  logic              load_in;
  logic              store_hidden;
  logic              store_out;
  logic              rd_en;
  logic [K_W-1:0]    last_k;
  logic [N_W-1:0]    last_n;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] product;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] relu_sum;

  for (genvar gi = 0; gi < IN_DIM; gi++) begin : g_unpack
    assign in_elem[gi] = bus.in_data[gi*DATA_W +: DATA_W];
  end

  for (genvar gi = 0; gi < OUT_DIM; gi++) begin : g_pack
    assign bus.out_data[gi*DATA_W +: DATA_W] = out_reg[gi];
  end

  // w_data in slot cycle k belongs to element k-1, so pair it with that operand.
  always_comb begin
    operand = '0;
    for (int i = 0; i < IN_DIM; i++) begin
      if (state_reg == L1 && k_reg == K_W'(i + 1)) operand = x_reg[i];
    end
    for (int i = 0; i < L1_DIM; i++) begin
      if (state_reg == L2 && k_reg == K_W'(i + 1)) operand = hidden_reg[i];
    end
  end

  // Low DATA_W bits of the product are identical for signed and unsigned operands.
  assign product  = bus.w_data * operand;
  assign sum      = acc_reg + product;
  assign relu_sum = sum[DATA_W-1] ? '0 : sum;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    n_next       = n_reg;
    acc_next     = acc_reg;
    addr_next    = addr_reg;
    load_in      = 1'b0;
    store_hidden = 1'b0;
    store_out    = 1'b0;
    rd_en        = 1'b0;
    last_k       = (state_reg == L2) ? K_W'(L1_DIM) : K_W'(IN_DIM);
    last_n       = (state_reg == L2) ? N_W'(OUT_DIM - 1) : N_W'(L1_DIM - 1);

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          load_in    = 1'b1;
          state_next = L1;
          k_next     = '0;
          n_next     = '0;
          acc_next   = '0;
        end
      end

      L1, L2: begin
        if (k_reg < last_k) begin
          rd_en = 1'b1;
          if (state_reg == L1)
            addr_next = ADDR_W'(n_reg) * ADDR_W'(IN_DIM) + ADDR_W'(k_reg);
          else
            addr_next = ADDR_W'(L2_BASE) + ADDR_W'(n_reg) * ADDR_W'(L1_DIM)
                      + ADDR_W'(k_reg);
        end

        if (k_reg != '0) acc_next = sum;

        // Final slot cycle: commit the finished neuron and start the next one clean.
        if (k_reg == last_k) begin
          acc_next     = '0;
          k_next       = '0;
          store_hidden = (state_reg == L1);
          store_out    = (state_reg == L2);
          if (n_reg == last_n) begin
            n_next     = '0;
            state_next = (state_reg == L1) ? L2 : DONE;
          end else begin
            n_next = n_reg + N_W'(1);
          end
        end else begin
          k_next = k_reg + K_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_reg    <= '0;
      n_reg    <= '0;
      acc_reg  <= '0;
      addr_reg <= '0;
    end else begin
      k_reg    <= k_next;
      n_reg    <= n_next;
      acc_reg  <= acc_next;
      addr_reg <= addr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IN_DIM; i++)  x_reg[i]      <= '0;
      for (int i = 0; i < L1_DIM; i++)  hidden_reg[i] <= '0;
      for (int i = 0; i < OUT_DIM; i++) out_reg[i]    <= '0;
    end else begin
      for (int i = 0; i < IN_DIM; i++) begin
        if (load_in) x_reg[i] <= in_elem[i];
      end
      for (int i = 0; i < L1_DIM; i++) begin
        if (store_hidden && n_reg == N_W'(i)) hidden_reg[i] <= relu_sum;
      end
      for (int i = 0; i < OUT_DIM; i++) begin
        if (store_out && n_reg == N_W'(i)) out_reg[i] <= relu_sum;
      end
    end
  end

  // w_addr shows the live address while reading and otherwise holds the last one issued.
  assign bus.w_rd_en   = rd_en;
  assign bus.w_addr    = addr_next;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.in_ready  = (state_reg == IDLE) && !reset;
  assign bus.out_valid = (state_reg == DONE);
endmodule
